// File: rtl/gps_sample_capture.sv
// gps_sample_capture: packs GPS samples LSB-first into RD_W words held in an
// on-chip simple dual-port RAM. A capture runs one-shot (it stops when the
// buffer is full) or as a ring (it overwrites the oldest words until stop).
// When the capture is over, the buffer is read back one word per rd.
//
// Parameters: SAMPLE_W bits per sample (1, 2, 4, 8); RD_W word width
// (8, 16, 32); DEPTH_BITS is log2 of the buffer capacity in bits.
//
// Ports:
//   clk, rst_n             clock and synchronous active-low reset
//   din, din_vld           sample data and its valid strobe
//   arm, stop, mode        start a capture, end it early, 0 one-shot / 1 ring
//   rd, dout               advance the read pointer, read data
//   done, wr_count         capture complete, number of samples stored
//
// Ring mode exists only when GPS_CAPTURE_RING_EN is defined. Without it,
// mode is ignored, every capture is one-shot and no wrap logic is built.
module gps_sample_capture #(
  parameter int SAMPLE_W   = 1,
  parameter int RD_W       = 16,
  parameter int DEPTH_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] din,
  input  logic                din_vld,
  input  logic                arm,
  input  logic                stop,
  input  logic                mode,
  input  logic                rd,
  output logic [RD_W-1:0]     dout,
  output logic                done,
  output logic [DEPTH_BITS:0] wr_count
);

  localparam int SPW   = RD_W / SAMPLE_W;
  localparam int AW    = DEPTH_BITS - $clog2(RD_W);
  localparam int WORDS = 1 << AW;
  localparam int CW    = (SPW > 1) ? $clog2(SPW) : 1;

  localparam logic [CW-1:0] LASTC = CW'(SPW - 1);
  localparam logic [CW-1:0] C1    = CW'(1);
  localparam logic [AW-1:0] W1    = AW'(1);

  localparam logic [DEPTH_BITS:0] ONE  = (DEPTH_BITS + 1)'(1);
  localparam logic [DEPTH_BITS:0] SCAP =
    ONE << (DEPTH_BITS - $clog2(SAMPLE_W));
  localparam logic [DEPTH_BITS:0] SCAP_M1 = SCAP - ONE;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FLUSH,
    DONE
  } state_e;

  state_e              state_q;
  logic [RD_W-1:0]     pack_q;
  logic [RD_W-1:0]     wdat_q;
  logic                wen_q;
  logic [CW-1:0]       cnt_q;
  logic [AW-1:0]       wptr_q;
  logic [AW-1:0]       wptr_d;
  logic [AW-1:0]       rptr_q;
  logic [AW-1:0]       rptr_d;
  logic [DEPTH_BITS:0] wr_count_q;
  logic                done_q;
  logic [RD_W-1:0]     dout_q;

  logic [RD_W-1:0] mem [WORDS];

  logic [RD_W-1:0] word_d;
  logic [RD_W-1:0] ram_wd;
  logic [RD_W-1:0] rdata;
  logic [AW-1:0]   start_addr;
  logic            ram_we;
  logic            ring;
  logic            start;
  logic            last_smp;
  logic            enter_done;
  logic            rd_upd;

  // A new capture may begin from any state except the one-cycle flush.
  assign start = arm && (state_q != FLUSH);

  assign word_d = pack_q | (RD_W'(din) << (cnt_q * SAMPLE_W));

  // Final one-shot sample: takes priority over a coincident stop.
  assign last_smp = (state_q == FILL) && din_vld && !ring &&
                    (wr_count_q == SCAP_M1);

  assign enter_done = (state_q == FLUSH) || last_smp;

  // Write port: a completed word lands one cycle after its last sample;
  // in FLUSH a partial word (upper bits still zero) is written instead.
  always_comb begin
    ram_we = wen_q;
    ram_wd = wdat_q;
    if (!wen_q && (state_q == FLUSH) && (cnt_q != '0)) begin
      ram_we = 1'b1;
      ram_wd = pack_q;
    end
  end

  assign wptr_d = ram_we ? (wptr_q + W1) : wptr_q;

`ifdef GPS_CAPTURE_RING_EN
  logic ring_q;
  logic wrap_q;
  logic wrap_now;

  assign ring     = ring_q;
  assign wrap_now = ram_we && (wptr_q == AW'(WORDS - 1));

  // After a wrap the oldest word sits where the next write would go.
  assign start_addr = (ring_q && (wrap_q || wrap_now)) ? wptr_d : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ring_q <= 1'b0;
      wrap_q <= 1'b0;
    end else if (start) begin
      ring_q <= mode;
      wrap_q <= 1'b0;
    end else if (wrap_now) begin
      wrap_q <= 1'b1;
    end
  end
`else
  logic unused_mode;

  assign unused_mode = mode;
  assign ring        = 1'b0;
  assign start_addr  = '0;
`endif

  // Look-ahead read address so back-to-back rd streams a word per cycle.
  always_comb begin
    rptr_d = rptr_q;
    rd_upd = 1'b0;
    if (start) begin
      rptr_d = '0;
    end else if (enter_done) begin
      rptr_d = start_addr;
      rd_upd = 1'b1;
    end else if ((state_q == DONE) && rd) begin
      rptr_d = rptr_q + W1;
      rd_upd = 1'b1;
    end
  end

  // Forward a same-cycle write so the word read on DONE entry is current.
  assign rdata = (ram_we && (wptr_q == rptr_d)) ? ram_wd : mem[rptr_d];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[wptr_q] <= ram_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pack_q     <= '0;
      wdat_q     <= '0;
      wen_q      <= 1'b0;
      cnt_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      wr_count_q <= '0;
      done_q     <= 1'b0;
      dout_q     <= '0;
    end else begin
      wen_q  <= 1'b0;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (rd_upd) begin
        dout_q <= rdata;
      end
      if (start) begin
        state_q    <= FILL;
        pack_q     <= '0;
        cnt_q      <= '0;
        wptr_q     <= '0;
        wr_count_q <= '0;
        done_q     <= 1'b0;
      end else begin
        case (state_q)
          FILL: begin
            if (din_vld) begin
              if (wr_count_q != SCAP) begin
                wr_count_q <= wr_count_q + ONE;
              end
              if (cnt_q == LASTC) begin
                wdat_q <= word_d;
                wen_q  <= 1'b1;
                pack_q <= '0;
                cnt_q  <= '0;
              end else begin
                pack_q <= word_d;
                cnt_q  <= cnt_q + C1;
              end
            end
            if (last_smp) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (stop) begin
              state_q <= FLUSH;
            end
          end
          FLUSH: begin
            pack_q  <= '0;
            cnt_q   <= '0;
            state_q <= DONE;
            done_q  <= 1'b1;
          end
          IDLE, DONE: begin
            state_q <= state_q;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign dout     = dout_q;
  assign done     = done_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_gps_sample_capture.sv
// tb_gps_sample_capture: directed bench for gps_sample_capture with a
// scoreboard queue of expected read words.
module tb_gps_sample_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        din0, vld0, arm0, stop0, mode0, rd0;
  logic [15:0] dout0;
  logic        done0;
  logic [8:0]  wc0;
  logic [3:0]  din1;
  logic        vld1, arm1, stop1, mode1, rd1;
  logic [15:0] dout1;
  logic        done1;
  logic [8:0]  wc1;

  int ntests = 0;
  int nfail  = 0;
  logic [31:0] sb[$];

`ifdef GPS_CAPTURE_RING_EN
  localparam int FIRST_W = 4;
`else
  localparam int FIRST_W = 0;
`endif
  localparam int LAST_W = FIRST_W + 15;

  gps_sample_capture #(
    .SAMPLE_W(1), .RD_W(16), .DEPTH_BITS(8)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .din(din0), .din_vld(vld0),
    .arm(arm0), .stop(stop0), .mode(mode0), .rd(rd0),
    .dout(dout0), .done(done0), .wr_count(wc0)
  );

  gps_sample_capture #(
    .SAMPLE_W(4), .RD_W(16), .DEPTH_BITS(8)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .din(din1), .din_vld(vld1),
    .arm(arm1), .stop(stop1), .mode(mode1), .rd(rd1),
    .dout(dout1), .done(done1), .wr_count(wc1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_word0(input logic [15:0] w);
    for (int b = 0; b < 16; b++) begin
      din0 = w[b];
      vld0 = 1'b1;
      tick;
    end
    vld0 = 1'b0;
  endtask

  task automatic arm_u0(input logic m);
    arm0  = 1'b1;
    mode0 = m;
    tick;
    arm0  = 1'b0;
    mode0 = 1'b0;
  endtask

  task automatic read0(input string tag, input int n);
    logic [31:0] e;
    rd0 = 1'b1;
    for (int k = 0; k < n; k++) begin
      e = (sb.size() != 0) ? sb.pop_front() : 32'hxxxx_xxxx;
      chk(tag, 32'(dout0), e);
      if (k < n - 1) tick;
    end
    rd0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] e;
    rst_n = 1'b0;
    {din0, vld0, arm0, stop0, mode0, rd0} = '0;
    {din1, vld1, arm1, stop1, mode1, rd1} = '0;
    tick;
    tick;
    rst_n = 1'b1;
    chk("rst_done0", 32'(done0), 0);
    chk("rst_wc0", 32'(wc0), 0);
    chk("rst_dout0", 32'(dout0), 0);
    chk("rst_done1", 32'(done1), 0);
    chk("rst_wc1", 32'(wc1), 0);

    // One-shot full capture of an A5A5 pattern.
    arm_u0(1'b0);
    for (int n = 0; n < 16; n++) begin
      drive_word0(16'hA5A5);
      sb.push_back(32'hA5A5);
    end
    chk("full_done", 32'(done0), 1);
    chk("full_wc", 32'(wc0), 256);
    read0("full_rd", 16);

    // Reset in the middle of a capture, then capture again.
    arm_u0(1'b0);
    for (int n = 0; n < 6; n++) drive_word0(16'h1234);
    for (int b = 0; b < 4; b++) begin
      din0 = 1'b1;
      vld0 = 1'b1;
      tick;
    end
    vld0  = 1'b0;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("midrst_done", 32'(done0), 0);
    chk("midrst_wc", 32'(wc0), 0);
    chk("midrst_dout", 32'(dout0), 0);
    tick;
    chk("midrst_idle", 32'(done0), 0);
    arm_u0(1'b0);
    for (int n = 0; n < 16; n++) begin
      drive_word0(16'hA5A5);
      sb.push_back(32'hA5A5);
    end
    chk("rearm_done", 32'(done0), 1);
    chk("rearm_wc", 32'(wc0), 256);
    read0("rearm_rd", 16);

    // Four-bit samples, early stop with a partial word.
    arm1 = 1'b1;
    tick;
    arm1 = 1'b0;
    for (int s = 1; s <= 5; s++) begin
      din1 = 4'(s);
      vld1 = 1'b1;
      tick;
    end
    vld1 = 1'b0;
    sb.push_back(32'h4321);
    sb.push_back(32'h0005);
    stop1 = 1'b1;
    tick;
    stop1 = 1'b0;
    chk("stop_done_early", 32'(done1), 0);
    tick;
    chk("stop_done", 32'(done1), 1);
    chk("stop_wc", 32'(wc1), 5);
    e = sb.pop_front();
    chk("stop_w0", 32'(dout1), e);
    rd1 = 1'b1;
    tick;
    rd1 = 1'b0;
    e = sb.pop_front();
    chk("stop_w1", 32'(dout1), e);

    // Ring request: 20 words with word n = n.
    arm_u0(1'b1);
    for (int n = 0; n < 20; n++) begin
      drive_word0(16'(n));
      if (n >= FIRST_W && n <= LAST_W) sb.push_back(32'(n));
    end
    stop0 = 1'b1;
    tick;
    stop0 = 1'b0;
    tick;
    chk("ring_done", 32'(done0), 1);
    chk("ring_wc", 32'(wc0), 256);
    read0("ring_rd", 16);

    // arm together with rd while done: arm wins, dout holds.
    arm0 = 1'b1;
    rd0  = 1'b1;
    tick;
    arm0 = 1'b0;
    rd0  = 1'b0;
    chk("armrd_done", 32'(done0), 0);
    chk("armrd_dout", 32'(dout0), 32'(LAST_W));
    chk("armrd_wc", 32'(wc0), 0);
    rd0 = 1'b1;
    tick;
    rd0 = 1'b0;
    chk("fill_rd_ignored", 32'(dout0), 32'(LAST_W));
    for (int n = 7; n < 10; n++) begin
      drive_word0(16'(n));
      sb.push_back(32'(n));
    end
    stop0 = 1'b1;
    tick;
    stop0 = 1'b0;
    tick;
    chk("armrd_done2", 32'(done0), 1);
    chk("armrd_wc2", 32'(wc0), 48);
    read0("armrd_rd", 3);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
